mem_write_buffer: RTL and testbench

Posted write-back buffer between the data cache controller and `Data_Memory` on the 256-bit line interface. It accepts dirty-line evictions from the cache and acknowledges them after one cycle, then drains them to memory in the background. Read misses reach memory ahead of pending drains, and a read of a line still held in the buffer is forwarded from it. The cache-side and memory-side ports use the same enable/write/ack handshake as the existing cache–memory link, so the block drops in between the two unchanged.

---
 rtl/mem_write_buffer.sv | 135 +++++++++++++
 tb/tb_mem_write_buffer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_buffer.sv
// mem_write_buffer: posted write-back line buffer with read forwarding between cache and memory
module mem_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cache_addr_i,
  input  logic [255:0] cache_data_i,
  input  logic         cache_enable_i,
  input  logic         cache_write_i,
  output logic         cache_ack_o,
  output logic [255:0] cache_data_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic         mem_ack_i,
  input  logic [255:0] mem_data_i,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic {U_IDLE, U_WAIT} u_state_e;
  typedef enum logic [1:0] {D_IDLE, D_DRAIN, D_READ} d_state_e;
  u_state_e u_q;
  d_state_e d_q;
  logic [26:0] line_q [DEPTH];
  logic [255:0] buf_q [DEPTH];
  logic [AW-1:0] head_q, tail_q, hit_idx, off;
  logic [AW:0] count_q, count_d;
  logic ack_q, pend_q, mem_en_q, mem_wr_q;
  logic [255:0] rdata_q;
  logic [26:0] rd_line_q, req_line;
  logic hit, hit_busy, wr_try, rd_try, coalesce, push, wr_done, rd_hit, rd_miss, pop, rd_done;
  logic unused_low_addr;
  assign req_line = cache_addr_i[31:5];
  assign unused_low_addr = ^cache_addr_i[4:0];
  // Search the occupied slots (offset from head below count) for the requested line
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - head_q;
      if ({1'b0, off} < count_q && line_q[i] == req_line) begin
        hit = 1'b1;
        hit_idx = AW'(i);
      end
    end
  end
  // A write may retry every cycle while waiting; reads are only sampled in U_IDLE
  assign hit_busy = hit && d_q == D_DRAIN && hit_idx == head_q;
  assign wr_try   = cache_enable_i && cache_write_i && !ack_q;
  assign rd_try   = u_q == U_IDLE && cache_enable_i && !cache_write_i && !ack_q;
  assign coalesce = wr_try && hit && !hit_busy;
  assign push     = wr_try && !hit && count_q < FULL;
  assign wr_done  = coalesce || push;
  assign rd_hit   = rd_try && hit;
  assign rd_miss  = rd_try && !hit;
  assign pop      = d_q == D_DRAIN && mem_ack_i;
  assign rd_done  = d_q == D_READ && mem_ack_i;
  assign count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  // Upstream and downstream FSMs, FIFO pointers and registered handshakes
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      u_q       <= U_IDLE;
      d_q       <= D_IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ack_q     <= 1'b0;
      pend_q    <= 1'b0;
      rd_line_q <= '0;
      rdata_q   <= '0;
      mem_en_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
    end else begin
      head_q  <= head_q + AW'(pop);
      tail_q  <= tail_q + AW'(push);
      count_q <= count_d;
      ack_q   <= wr_done || rd_hit || rd_done;
      if (rd_hit) rdata_q <= buf_q[hit_idx];
      else if (rd_done) rdata_q <= mem_data_i;
      if (rd_miss) begin
        pend_q    <= 1'b1;
        rd_line_q <= req_line;
      end
      case (u_q)
        U_IDLE:  if ((wr_try && !wr_done) || rd_miss) u_q <= U_WAIT;
        U_WAIT:  if (wr_done || rd_done) u_q <= U_IDLE;
        default: u_q <= U_IDLE;
      endcase
      case (d_q)
        D_IDLE:
          if (pend_q) begin
            d_q      <= D_READ;
            mem_en_q <= 1'b1;
            mem_wr_q <= 1'b0;
          end else if (count_q != '0) begin
            d_q      <= D_DRAIN;
            mem_en_q <= 1'b1;
            mem_wr_q <= 1'b1;
          end
        D_DRAIN:
          if (mem_ack_i) begin
            d_q      <= D_IDLE;
            mem_en_q <= 1'b0;
            mem_wr_q <= 1'b0;
          end
        D_READ:
          if (mem_ack_i) begin
            d_q      <= D_IDLE;
            mem_en_q <= 1'b0;
            pend_q   <= 1'b0;
          end
        default: d_q <= D_IDLE;
      endcase
    end
  end
  // Line storage: push at tail, coalesce in place (never onto the in-flight head)
  always_ff @(posedge clk_i) begin
    if (push) begin
      line_q[tail_q] <= req_line;
      buf_q[tail_q]  <= cache_data_i;
    end
    if (coalesce) buf_q[hit_idx] <= cache_data_i;
  end
  assign cache_ack_o  = ack_q;
  assign cache_data_o = rdata_q;
  assign mem_enable_o = mem_en_q;
  assign mem_write_o  = mem_wr_q;
  assign mem_addr_o   = d_q == D_READ ? {rd_line_q, 5'b0} : d_q == D_DRAIN ? {line_q[head_q], 5'b0} : '0;
  assign mem_data_o   = d_q == D_DRAIN ? buf_q[head_q] : '0;
  assign empty_o      = count_q == '0 && d_q == D_IDLE && !pend_q;
endmodule

// File: tb/tb_mem_write_buffer.sv
// tb_mem_write_buffer: directed, table-driven and random checks of the posted write buffer
module tb_mem_write_buffer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [255:0] wdata = '0;
  logic en = 1'b0, wr = 1'b0;
  logic cache_ack_o, mem_enable_o, mem_write_o, empty_o;
  logic [255:0] cache_data_o, mem_data_o;
  logic [31:0] mem_addr_o;
  logic mem_ack = 1'b0;
  logic [255:0] mem_rdata = '0;
  int checks = 0, errors = 0;
  int mlat = 1, cnt = 0;
  logic [255:0] mem [bit [26:0]];
  typedef struct {bit wr; logic [26:0] line;} op_t;
  op_t oplog[$];
  typedef struct {bit wr; logic [31:0] a; logic [255:0] d; bit fast; bit cd; logic [255:0] exp;} vec_t;
  vec_t tbl[7];
  localparam logic [255:0] P0 = 256'h0000_1001_2002_3003_4004_5005_6006_7007_8008_9009_A00A_B00B_C00C_D00D_E00E_F00F;
  mem_write_buffer #(.DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .cache_addr_i(addr), .cache_data_i(wdata), .cache_enable_i(en), .cache_write_i(wr),
    .cache_ack_o(cache_ack_o), .cache_data_o(cache_data_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_enable_o(mem_enable_o),
    .mem_write_o(mem_write_o), .mem_ack_i(mem_ack), .mem_data_i(mem_rdata),
    .empty_o(empty_o)
  );
  always #5 clk = ~clk;
  function automatic logic [255:0] mrd(input bit [26:0] l);
    return mem.exists(l) ? mem[l] : '0;
  endfunction
  function automatic int nwrites(input bit [26:0] l);
    int n = 0;
    foreach (oplog[i]) if (oplog[i].wr && oplog[i].line == l) n++;
    return n;
  endfunction
  function automatic logic [255:0] pat(input logic [31:0] w);
    return {8{w}};
  endfunction
  // Memory model: acknowledges a held request after mlat cycles and logs each access
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!rst_n) cnt = 0;
    else if (mem_enable_o) begin
      cnt++;
      if (cnt >= mlat) begin
        cnt = 0;
        mem_ack = 1'b1;
        if (mem_write_o) mem[mem_addr_o[31:5]] = mem_data_o;
        else mem_rdata = mrd(mem_addr_o[31:5]);
        oplog.push_back(op_t'{mem_write_o, mem_addr_o[31:5]});
      end
    end
  end
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic req(input bit w, input logic [31:0] a, input logic [255:0] d, output int lat, output logic [255:0] rd);
    @(negedge clk);
    en = 1'b1; wr = w; addr = a; wdata = d; lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cache_ack_o && lat < 400);
    rd = cache_data_o;
    en = 1'b0;
  endtask
  task automatic wait_empty(input string name);
    int n = 0;
    while (!empty_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, empty_o, 1);
  endtask
  task automatic wait_en(input string name);
    int n = 0;
    while (!mem_enable_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, mem_enable_o, 1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    int lat;
    logic [255:0] rd;
    logic [255:0] model_q [8];
    logic [26:0] exp_lines [5];
    do_reset();
    chk("reset ack", cache_ack_o, 0);
    chk("reset mem_enable", mem_enable_o, 0);
    chk("reset mem_addr", mem_addr_o, 0);
    chk("reset cache_data", cache_data_o, 0);
    chk("reset empty", empty_o, 1);
    // Posted write
    mlat = 1;
    oplog.delete();
    req(1, 32'h400, P0, lat, rd);
    chk("posted ack latency", lat, 1);
    wait_empty("posted empty");
    chk("posted mem data", mrd(27'h20), P0);
    chk("posted one write", nwrites(27'h20), 1);
    // Table: coalesce, forwarding (including in-flight head) and a read miss
    mlat = 10;
    oplog.delete();
    tbl[0] = '{1, 32'h3E0, pat(32'hAAAA_0001), 1, 0, '0};
    tbl[1] = '{0, 32'h3E4, '0, 1, 1, pat(32'hAAAA_0001)};
    tbl[2] = '{1, 32'h220, pat(32'hAAAA_000A), 1, 0, '0};
    tbl[3] = '{1, 32'h22C, pat(32'hBBBB_000B), 1, 0, '0};
    tbl[4] = '{0, 32'h220, '0, 1, 1, pat(32'hBBBB_000B)};
    tbl[5] = '{1, 32'h240, pat(32'hCCCC_000C), 1, 0, '0};
    tbl[6] = '{0, 32'h400, '0, 0, 1, P0};
    foreach (tbl[i]) begin
      if (i == 6) chk("no memory read before miss", oplog.size() == 0 || !oplog[$].wr ? 0 : 1, oplog.size() == 0 ? 0 : 1);
      req(tbl[i].wr, tbl[i].a, tbl[i].d, lat, rd);
      if (tbl[i].fast) chk($sformatf("tbl[%0d] latency", i), lat, 1);
      else chk($sformatf("tbl[%0d] slow ack", i), lat > 1 && lat < 400, 1);
      if (tbl[i].cd) chk($sformatf("tbl[%0d] data", i), rd, tbl[i].exp);
    end
    wait_empty("table empty");
    chk("table line 31", mrd(27'h1F), pat(32'hAAAA_0001));
    chk("table line 17", mrd(27'h11), pat(32'hBBBB_000B));
    chk("table line 18", mrd(27'h12), pat(32'hCCCC_000C));
    chk("table coalesced once", nwrites(27'h11), 1);
    chk("table one read", oplog.size(), 4);
    // Full: fifth distinct line waits for the first drain
    mlat = 12;
    oplog.delete();
    exp_lines = '{27'h0, 27'h1, 27'h2, 27'h10, 27'h12};
    foreach (exp_lines[i]) begin
      req(1, {exp_lines[i], 5'b0}, pat(32'hF000_0000 + i), lat, rd);
      if (i < 4) chk($sformatf("full write %0d latency", i), lat, 1);
      else begin
        chk("full fifth withheld", lat > 1 && lat < 400, 1);
        chk("full fifth after one drain", oplog.size(), 1);
      end
    end
    wait_empty("full empty");
    chk("full drain count", oplog.size(), 5);
    foreach (exp_lines[i]) if (i < oplog.size()) chk($sformatf("full order %0d", i), {oplog[i].wr, oplog[i].line}, {1'b1, exp_lines[i]});
    // Read priority over queued drains
    oplog.delete();
    req(1, 32'h060, pat(32'h3333_3333), lat, rd);
    req(1, 32'h080, pat(32'h4444_4444), lat, rd);
    req(1, 32'h0A0, pat(32'h5555_5555), lat, rd);
    req(0, 32'h400, '0, lat, rd);
    chk("prio read slow", lat > 1 && lat < 400, 1);
    chk("prio read data", rd, P0);
    chk("prio ops at read ack", oplog.size(), 2);
    wait_empty("prio empty");
    chk("prio op count", oplog.size(), 4);
    if (oplog.size() == 4) begin
      chk("prio op0", {oplog[0].wr, oplog[0].line}, {1'b1, 27'h3});
      chk("prio op1", {oplog[1].wr, oplog[1].line}, {1'b0, 27'h20});
      chk("prio op2", {oplog[2].wr, oplog[2].line}, {1'b1, 27'h4});
      chk("prio op3", {oplog[3].wr, oplog[3].line}, {1'b1, 27'h5});
    end
    // Rewrite of the line currently draining
    oplog.delete();
    req(1, 32'h040, pat(32'hE1E1_E1E1), lat, rd);
    chk("rewrite first latency", lat, 1);
    wait_en("rewrite drain start");
    req(1, 32'h040, pat(32'hE2E2_E2E2), lat, rd);
    chk("rewrite delayed", lat > 1 && lat < 400, 1);
    chk("rewrite after drain ack", nwrites(27'h2), 1);
    wait_empty("rewrite empty");
    chk("rewrite final data", mrd(27'h2), pat(32'hE2E2_E2E2));
    chk("rewrite two writes", nwrites(27'h2), 2);
    // Reset in the middle of a drain
    mlat = 20;
    oplog.delete();
    req(1, 32'h100, pat(32'hF1F1_F1F1), lat, rd);
    req(1, 32'h120, pat(32'hF2F2_F2F2), lat, rd);
    chk("midreset second latency", lat, 1);
    wait_en("midreset drain start");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset enable drops", mem_enable_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset empty", empty_o, 1);
    repeat (40) @(negedge clk);
    chk("midreset no memory ops", oplog.size(), 0);
    chk("midreset line 9 untouched", mrd(27'h9), 0);
    chk("midreset enable idle", mem_enable_o, 0);
    // Random traffic against a coherent-memory model
    for (int l = 0; l < 8; l++) model_q[l] = mrd(27'(l));
    for (int n = 0; n < 300; n++) begin
      int l;
      bit w;
      logic [255:0] d;
      l = $urandom_range(0, 7);
      w = $urandom_range(0, 1) == 1;
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom();
      mlat = $urandom_range(1, 5);
      req(w, {27'(l), 5'($urandom_range(0, 31))}, d, lat, rd);
      if (lat >= 400) chk($sformatf("rand %0d ack", n), lat, 1);
      if (w) model_q[l] = d;
      else chk($sformatf("rand %0d read line %0d", n, l), rd, model_q[l]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_empty("rand empty");
    for (int l = 0; l < 8; l++) chk($sformatf("rand mem line %0d", l), mrd(27'(l)), model_q[l]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
